// File: rtl/rd_scoreboard.sv
// Register-write scoreboard: tracks in-flight destination writes per register
// and raises a decode stall when a used source still has a pending write.
module rd_scoreboard #(
  parameter int AW   = 5,
  parameter int NREG = 32,
  parameter int CW   = 2
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            issue_en,
  input  logic [AW-1:0]   issue_rd,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_rd,
  input  logic [AW-1:0]   rs1,
  input  logic            rs1_used,
  input  logic [AW-1:0]   rs2,
  input  logic            rs2_used,
  output logic            stall,
  output logic [NREG-1:0] busy_mask,
  output logic            overflow,
  output logic            underflow
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  logic [NREG-1:0] pending;    // current counter != 0
  logic [NREG-1:0] busy_next;  // updated counter != 0
  logic [NREG-1:0] ovf_hit;
  logic [NREG-1:0] unf_hit;
  logic [NREG-1:0] busy_mask_reg;
  logic            overflow_reg;
  logic            underflow_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        // Register 0 is hard-wired; it is never counted and never errors.
        assign pending[gi]   = 1'b0;
        assign busy_next[gi] = 1'b0;
        assign ovf_hit[gi]   = 1'b0;
        assign unf_hit[gi]   = 1'b0;
      end else begin : g_cnt
        logic [CW-1:0] cnt_reg;
        logic [CW-1:0] cnt_next;
        logic          inc;
        logic          dec;
        logic          ovf;
        logic          unf;

        always_comb begin
          inc      = issue_en && (issue_rd == AW'(gi));
          dec      = wb_en && (wb_rd == AW'(gi));
          cnt_next = cnt_reg;
          ovf      = 1'b0;
          unf      = 1'b0;
          // Simultaneous issue and writeback cancel with no error checks.
          if (inc && !dec) begin
            if (cnt_reg == CNT_MAX) ovf = 1'b1;
            else                    cnt_next = cnt_reg + 1'b1;
          end else if (dec && !inc) begin
            if (cnt_reg == '0) unf = 1'b1;
            else               cnt_next = cnt_reg - 1'b1;
          end
        end

        always_ff @(posedge clk) begin
          if (clr) cnt_reg <= '0;
          else     cnt_reg <= cnt_next;
        end

        assign pending[gi]   = (cnt_reg != '0);
        assign busy_next[gi] = (cnt_next != '0);
        assign ovf_hit[gi]   = ovf;
        assign unf_hit[gi]   = unf;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (clr) begin
      busy_mask_reg <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      busy_mask_reg <= busy_next;
      overflow_reg  <= overflow_reg | (|ovf_hit);
      underflow_reg <= underflow_reg | (|unf_hit);
    end
  end

  // No writeback bypass: stall follows the registered counters only.
  assign stall = (rs1_used && (rs1 != '0) && pending[rs1]) ||
                 (rs2_used && (rs2 != '0) && pending[rs2]);

  assign busy_mask = busy_mask_reg;
  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;

endmodule

// File: doc/rd_scoreboard.md
Name: rd_scoreboard

Overview:
- Tracks outstanding register-file writes in the pipeline.
- Each issued instruction's 5-bit destination tag is counted in at issue. The same tag is counted out when the writeback stage retires it.
- Source tags are checked against the outstanding set to produce a stall for the decode stage.
- Sits between decode/issue and writeback, on the consumer side of the pipeline-latch rd tags.

Parameters:
- AW, 5, register tag width.
- NREG, 32, number of architectural registers (2^AW).
- CW, 2, width of per-register in-flight counter; max in-flight writes per register = 2^CW-1.

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  reset; synchronous, active-high, sampled on rising edge of clk.
- issue_en  input  1  instruction with a register write leaves decode this cycle.
- issue_rd  input  AW  destination tag of issuing instruction.
- wb_en  input  1  writeback stage commits a register write this cycle.
- wb_rd  input  AW  destination tag being written back.
- rs1  input  AW  source tag A queried by decode.
- rs1_used  input  1  instruction in decode reads rs1.
- rs2  input  AW  source tag B queried by decode.
- rs2_used  input  1  instruction in decode reads rs2.
- stall  output  1  decode must hold: a used source has a pending write.
- busy_mask  output  NREG  bit i = register i has count != 0; registered.
- overflow  output  1  sticky error: issue to a register at max count.
- underflow  output  1  sticky error: writeback to a register at count 0.

Behaviour:
- State: NREG counters of CW bits each, plus sticky overflow and underflow flags.
- Reset (clr=1 at a clock edge): all counters 0, busy_mask=0, overflow=0, underflow=0. Reset overrides issue and writeback in the same cycle.
- Register 0 never tracked:
  - issue_rd=0 and wb_rd=0 are ignored and never raise errors.
  - busy_mask[0] is always 0.
- Per clock edge, for register r != 0:
  - inc = issue_en & (issue_rd==r); dec = wb_en & (wb_rd==r).
  - inc & !dec: count+1. If count == max, count holds and overflow is set.
  - dec & !inc: count-1. If count == 0, count holds and underflow is set.
  - inc & dec: count unchanged. No error, even at max or 0.
  - Otherwise: count unchanged.
- Overflow and underflow, once set, remain 1 until clr.
- busy_mask is registered from the updated counters, so it reflects an issue or writeback one cycle after the edge that samples it.
- stall is combinational from the current registered counters only. No same-cycle bypass of wb_en:
  - stall = (rs1_used & rs1!=0 & count[rs1]!=0) | (rs2_used & rs2!=0 & count[rs2]!=0).
  - A writeback retiring the last pending write clears stall the cycle after the edge.
- Issue and writeback of different registers in the same cycle are independent.
- Latency:
  - Issue to visible busy/stall: 1 cycle.
  - Writeback to cleared busy/stall: 1 cycle.
- No backpressure. The block never blocks issue or writeback; errors are report-only.

Test Plan:
- Reset: clr=1 for 1 cycle with issue_en=1, issue_rd=5 → after edge busy_mask=0, overflow=0, underflow=0, stall=0.
- Basic hazard:
  - issue_en=1, issue_rd=7 at cycle 0 → busy_mask=0x00000080 from cycle 1.
  - rs1=7, rs1_used=1 → stall=1.
  - wb_en=1, wb_rd=7 at cycle 3 → busy_mask=0, stall=0 from cycle 4.
- Multiple in-flight writes: issue rd=3 on 3 consecutive cycles → busy after all three.
  - 2 writebacks → still busy, stall with rs2=3, rs2_used=1.
  - 3rd writeback → clear.
  - A 4th issue while count=3 → overflow=1 sticky, count stays 3.
- Simultaneous events:
  - Issue rd=9 and wb rd=9 in the same cycle with count=1 → count stays 1, no error.
  - Same with count=0 → count stays 0, no error.
  - Issue rd=4 with wb rd=6 (count 1) → bit4 set, bit6 cleared.
- Register 0 and unused sources:
  - issue_rd=0 and wb_rd=0 with count 0 → busy_mask[0]=0, underflow=0.
  - rs1=12 pending but rs1_used=0 → stall=0.
- Underflow and reset mid-operation:
  - wb rd=15 with count 0 → underflow=1, holds across cycles.
  - clr=1 while registers 2 and 5 are pending → all cleared next cycle, underflow=0.
